// File: rtl/midi_rx_parser_pkg.sv
// Shared MIDI definitions: status nibbles, message length lookup and the
// receiver state encoding used by the bit-level deserialiser.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PC       = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        if (status[7:4] == PC || status[7:4] == CH_AT)
            return 2'd1;
        return 2'd2;
    endfunction

endpackage

// File: rtl/midi_rx_parser_if.sv
// Serial input, consumer acknowledge and the held-message bundle of the
// MIDI receiver; master is the parser side, slave the consumer side.
interface midi_rx_parser_if;
    logic       rx;
    logic       msg_clr;
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [1:0] byte_cnt;
    logic       msg_valid;
    logic       msg_stb;
    logic       frame_err;

    modport master (
        input  rx, msg_clr,
        output status, data1, data2, byte_cnt,
        output msg_valid, msg_stb, frame_err
    );

    modport slave (
        output rx, msg_clr,
        input  status, data1, data2, byte_cnt,
        input  msg_valid, msg_stb, frame_err
    );
endinterface

// File: rtl/midi_uart_rx.sv
// 8N1 deserialiser: rx synchroniser, mid-bit sampling FSM, one-cycle
// byte_rdy / frame_err pulses registered right after the stop sample.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 3200,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_rdy,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;
    rx_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   armed_q, armed_d;
    logic                   rdy_q, rdy_d;
    logic                   ferr_q, ferr_d;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign rx_byte   = shift_q;
    assign byte_rdy  = rdy_q;
    assign frame_err = ferr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

    // armed_q drops after a low stop bit so a held break needs rx high first
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        armed_d = armed_q;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                armed_d = armed_q | rx_s;
                if (armed_q && !rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        rdy_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI input stage: UART receiver plus channel-voice parser with running
// status; holds the last complete message until the consumer clears it.
module midi_rx_parser
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 3200,
    parameter int SYNC_STAGES  = 2
) (
    input logic               clk,
    input logic               rst,
    midi_rx_parser_if.master  bus
);
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_i;
    logic [7:0] rx_byte;
    logic       byte_rdy;

    logic [7:0] rs_q, rs_d;
    logic       idx_q, idx_d;
    logic [7:0] d1_q, d1_d;
    logic [7:0] status_q, status_d;
    logic [7:0] data1_q, data1_d;
    logic [7:0] data2_q, data2_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic       valid_q, valid_d;
    logic       stb_q, stb_d;
    logic [1:0] need;
    logic       is_rt, is_sys, is_stat, is_data;

    // asynchronous assert, synchronous release of the internal reset
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_i      = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= rst_sync_d;
    end

    midi_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_uart (
        .clk       (clk),
        .rst       (rst_i),
        .rx        (bus.rx),
        .rx_byte   (rx_byte),
        .byte_rdy  (byte_rdy),
        .frame_err (bus.frame_err)
    );

    assign need    = midi_data_len(rs_q);
    assign is_rt   = rx_byte[7:3] == 5'b11111;
    assign is_sys  = rx_byte[7:3] == 5'b11110;
    assign is_stat = rx_byte[7] && rx_byte[7:4] != 4'hF;
    assign is_data = !rx_byte[7] && rs_q[7];

    assign bus.status    = status_q;
    assign bus.data1     = data1_q;
    assign bus.data2     = data2_q;
    assign bus.byte_cnt  = bcnt_q;
    assign bus.msg_valid = valid_q;
    assign bus.msg_stb   = stb_q;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            rs_q     <= '0;
            idx_q    <= 1'b0;
            d1_q     <= '0;
            status_q <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            bcnt_q   <= '0;
            valid_q  <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            rs_q     <= rs_d;
            idx_q    <= idx_d;
            d1_q     <= d1_d;
            status_q <= status_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            bcnt_q   <= bcnt_d;
            valid_q  <= valid_d;
            stb_q    <= stb_d;
        end
    end

    // a commit overrides msg_clr because it is assigned after the default
    always_comb begin
        rs_d     = rs_q;
        idx_d    = idx_q;
        d1_d     = d1_q;
        status_d = status_q;
        data1_d  = data1_q;
        data2_d  = data2_q;
        bcnt_d   = bcnt_q;
        valid_d  = valid_q & ~bus.msg_clr;
        stb_d    = 1'b0;
        if (byte_rdy) begin
            unique case (1'b1)
                is_rt: ;
                is_sys: begin
                    rs_d  = '0;
                    idx_d = 1'b0;
                end
                is_stat: begin
                    rs_d    = rx_byte;
                    idx_d   = 1'b0;
                    valid_d = 1'b0;
                end
                is_data: begin
                    if (!idx_q)
                        valid_d = 1'b0;
                    if (idx_q || need == 2'd1) begin
                        status_d = rs_q;
                        data1_d  = idx_q ? d1_q : rx_byte;
                        data2_d  = idx_q ? rx_byte : 8'h00;
                        bcnt_d   = need + 2'd1;
                        valid_d  = 1'b1;
                        stb_d    = 1'b1;
                        idx_d    = 1'b0;
                    end else begin
                        d1_d  = rx_byte;
                        idx_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Self-checking bench for midi_rx_parser: directed MIDI scenarios plus a
// randomized byte stream checked against a queue-based message model.
module tb_midi_rx_parser;

    localparam int CPB = 32;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] n;
        logic       v;
    } msg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    midi_rx_parser_if bus();

    midi_rx_parser #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    msg_t obs_q[$];
    msg_t exp_q[$];
    int   fe_cnt = 0;
    int   errors = 0;
    int   checks = 0;
    int   m_rs   = 0;
    int   m_dq[$];

    always @(negedge clk) begin
        if (bus.msg_stb === 1'b1)
            obs_q.push_back({bus.status, bus.data1, bus.data2,
                             bus.byte_cnt, bus.msg_valid});
        if (bus.frame_err === 1'b1)
            fe_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        @(posedge clk);
        bus.rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        bus.rx = stop_ok;
        repeat (CPB) @(posedge clk);
        bus.rx = 1'b1;
        if (!stop_ok)
            repeat (CPB) @(posedge clk);
        repeat (4) @(posedge clk);
    endtask

    // reference: running status plus a queue of pending data bytes
    task automatic model_byte(input logic [7:0] b);
        int need;
        if (b >= 8'hF8) begin
        end else if (b >= 8'hF0) begin
            m_rs = 0;
            m_dq.delete();
        end else if (b >= 8'h80) begin
            m_rs = b;
            m_dq.delete();
        end else if (m_rs != 0) begin
            m_dq.push_back(b);
            need = ((m_rs / 16) == 12 || (m_rs / 16) == 13) ? 1 : 2;
            if (m_dq.size() == need) begin
                exp_q.push_back({8'(m_rs), 8'(m_dq[0]),
                                 need == 2 ? 8'(m_dq[1]) : 8'h00,
                                 2'(need + 1), 1'b1});
                m_dq.delete();
            end
        end
    endtask

    task automatic test_reset();
        logic [28:0] outs;
        #1;
        outs = {bus.status, bus.data1, bus.data2, bus.byte_cnt,
                bus.msg_valid, bus.msg_stb, bus.frame_err};
        checks++;
        if (outs !== 29'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h want 0", outs);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        outs = {bus.status, bus.data1, bus.data2, bus.byte_cnt,
                bus.msg_valid, bus.msg_stb, bus.frame_err};
        checks++;
        if (outs !== 29'd0) begin
            errors++;
            $display("FAIL reset_release: got %h want 0", outs);
        end
    endtask

    task automatic test_cc();
        obs_q.delete();
        send_byte(8'hB0);
        send_byte(8'h2E);
        send_byte(8'h7F);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {8'hB0, 8'h2E, 8'h7F, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL cc_commit: got n=%0d %h want 1 B02E7F/3/1",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (bus.msg_valid !== 1'b1) begin
            errors++;
            $display("FAIL cc_valid_held: got %b want 1", bus.msg_valid);
        end
        send_byte(8'h01);
        @(negedge clk);
        checks++;
        if (bus.msg_valid !== 1'b0 || bus.data1 !== 8'h2E || obs_q.size() != 1) begin
            errors++;
            $display("FAIL rs_first_clears: got v=%b d1=%h n=%0d want 0 2E 1",
                     bus.msg_valid, bus.data1, obs_q.size());
        end
        send_byte(8'h02);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 2 || obs_q[1] !== {8'hB0, 8'h01, 8'h02, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL rs_cc_commit: got n=%0d want 2 with B00102/3/1", obs_q.size());
        end
        @(negedge clk);
        bus.msg_clr = 1'b1;
        @(negedge clk);
        bus.msg_clr = 1'b0;
        checks++;
        if (bus.msg_valid !== 1'b0 || bus.status !== 8'hB0) begin
            errors++;
            $display("FAIL msg_clr: got v=%b s=%h want 0 B0", bus.msg_valid, bus.status);
        end
    endtask

    task automatic test_running_status();
        obs_q.delete();
        send_byte(8'hC0);
        send_byte(8'h42);
        send_byte(8'h43);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL pc_count: got %0d want 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {8'hC0, 8'h42, 8'h00, 2'd2, 1'b1}) begin
                errors++;
                $display("FAIL pc_first: got %h", obs_q[0]);
            end
            checks++;
            if (obs_q[1] !== {8'hC0, 8'h43, 8'h00, 2'd2, 1'b1}) begin
                errors++;
                $display("FAIL pc_running: got %h", obs_q[1]);
            end
        end
    endtask

    task automatic test_realtime();
        obs_q.delete();
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'hF8);
        send_byte(8'h64);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {8'h90, 8'h3C, 8'h64, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL realtime_skip: got n=%0d %h want 1 903C64/3/1",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0);
        end
    endtask

    task automatic test_frame_err();
        int fe0;
        obs_q.delete();
        fe0 = fe_cnt;
        send_byte(8'h90);
        send_byte(8'h3C, 1'b0);
        checks++;
        if (fe_cnt - fe0 != 1 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL frame_err: got fe=%0d n=%0d want 1 0", fe_cnt - fe0, obs_q.size());
        end
        send_byte(8'h3C);
        send_byte(8'h40);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {8'h90, 8'h3C, 8'h40, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL frame_err_resume: got n=%0d want 1 903C40/3/1", obs_q.size());
        end
    endtask

    task automatic test_sysex_glitch();
        int fe0;
        obs_q.delete();
        fe0 = fe_cnt;
        send_byte(8'hF0);
        send_byte(8'h7D);
        send_byte(8'h01);
        send_byte(8'hF7);
        send_byte(8'h12);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL sysex_drop: got %0d commits want 0", obs_q.size());
        end
        @(posedge clk);
        bus.rx = 1'b0;
        repeat (10) @(posedge clk);
        bus.rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        checks++;
        if (fe_cnt != fe0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL glitch: got fe=%0d n=%0d want 0 0", fe_cnt - fe0, obs_q.size());
        end
        send_byte(8'hC0);
        send_byte(8'h11);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {8'hC0, 8'h11, 8'h00, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL glitch_recover: got n=%0d want 1 C01100/2/1", obs_q.size());
        end
    endtask

    task automatic test_break();
        int fe0;
        obs_q.delete();
        fe0 = fe_cnt;
        @(posedge clk);
        bus.rx = 1'b0;
        repeat (15 * CPB) @(posedge clk);
        checks++;
        if (fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL break_fe: got %0d want 1", fe_cnt - fe0);
        end
        bus.rx = 1'b1;
        repeat (CPB) @(posedge clk);
        send_byte(8'hD3);
        send_byte(8'h55);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {8'hD3, 8'h55, 8'h00, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL break_recover: got n=%0d want 1 D35500/2/1", obs_q.size());
        end
    endtask

    task automatic test_clr_commit();
        obs_q.delete();
        send_byte(8'h90);
        send_byte(8'h3C);
        bus.msg_clr = 1'b1;
        send_byte(8'h40);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {8'h90, 8'h3C, 8'h40, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL clr_vs_commit: got n=%0d %h want valid=1 at commit",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0);
        end
        checks++;
        if (bus.msg_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_after_commit: got %b want 0", bus.msg_valid);
        end
        bus.msg_clr = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         r;
        obs_q.delete();
        exp_q.delete();
        send_byte(8'hF7);
        model_byte(8'hF7);
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            if (r < 4)       b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 6)  b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r == 6) b = 8'($urandom_range(8'hF0, 8'hF7));
            else             b = 8'($urandom_range(0, 8'h7F));
            send_byte(b);
            model_byte(b);
        end
        @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_msg[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (exp_q.size() > 0) begin
            checks++;
            if ({bus.status, bus.data1, bus.data2, bus.byte_cnt} !==
                exp_q[exp_q.size()-1][26:1]) begin
                errors++;
                $display("FAIL rand_hold: got %h %h %h %0d", bus.status,
                         bus.data1, bus.data2, bus.byte_cnt);
            end
        end
    endtask

    task automatic test_rst_mid_data();
        logic [28:0] outs;
        send_byte(8'hB0);
        send_byte(8'h2E);
        send_byte(8'h7F);
        obs_q.delete();
        @(posedge clk);
        bus.rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        rst = 1'b0;
        #1;
        outs = {bus.status, bus.data1, bus.data2, bus.byte_cnt,
                bus.msg_valid, bus.msg_stb, bus.frame_err};
        checks++;
        if (outs !== 29'd0) begin
            errors++;
            $display("FAIL rst_mid_data: got %h want 0", outs);
        end
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        send_byte(8'h2E);
        send_byte(8'hB0);
        send_byte(8'h2E);
        send_byte(8'h7F);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {8'hB0, 8'h2E, 8'h7F, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL rst_recover: got n=%0d %h want 1 B02E7F/3/1",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0);
        end
    endtask

    initial begin
        bus.rx      = 1'b1;
        bus.msg_clr = 1'b0;
        #2;
        rst = 1'b0;
        test_reset();
        test_cc();
        test_running_status();
        test_realtime();
        test_frame_err();
        test_sysex_glitch();
        test_break();
        test_clr_commit();
        test_random();
        test_rst_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
